// File: rtl/vx_writeback_sink_if.sv
// Writeback valid/data channel from the commit stage: one beat per cycle, no backpressure.
interface vx_writeback_sink_if #(
    parameter int unsigned THREAD_CNT = 4,
    parameter int unsigned XLEN       = 32,
    parameter int unsigned WIS_W      = 2,
    parameter int unsigned NR_W       = 6,
    parameter int unsigned UUID_W     = 1
);
    logic                       wb_valid;
    logic [UUID_W-1:0]          wb_uuid;
    logic [WIS_W-1:0]           wb_wis;
    logic [THREAD_CNT-1:0]      wb_tmask;
    logic [XLEN-1:0]            wb_PC;
    logic [NR_W-1:0]            wb_rd;
    logic [THREAD_CNT*XLEN-1:0] wb_data;
    logic                       wb_sop;
    logic                       wb_eop;

    modport master (
        output wb_valid, wb_uuid, wb_wis, wb_tmask, wb_PC, wb_rd, wb_data, wb_sop, wb_eop
    );
    modport slave (
        input  wb_valid, wb_uuid, wb_wis, wb_tmask, wb_PC, wb_rd, wb_data, wb_sop, wb_eop
    );
endinterface

// File: rtl/vx_writeback_sink.sv
// Writeback sink: registers beats into the RF write port, frames sop/eop per issue slot and
// releases scoreboard pending bits. Optional perf counters under VX_WB_SINK_PERF_EN.
module vx_writeback_sink #(
    parameter  int unsigned THREAD_CNT = 4,
    parameter  int unsigned XLEN       = 32,
    parameter  int unsigned NUM_WIS    = 4,
    parameter  int unsigned NUM_REGS   = 64,
    parameter  int unsigned UUID_W     = 1,
    localparam int unsigned WIS_W      = (NUM_WIS > 1) ? $clog2(NUM_WIS) : 1,
    localparam int unsigned NR_W       = $clog2(NUM_REGS),
    localparam int unsigned CNT_W      = $clog2(NUM_WIS * NUM_REGS + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    vx_writeback_sink_if.slave         wb,
    input  logic                       rsv_valid,
    input  logic [WIS_W-1:0]           rsv_wis,
    input  logic [NR_W-1:0]            rsv_rd,
    output logic                       rsv_ready,
    output logic                       rf_we,
    output logic [WIS_W-1:0]           rf_wis,
    output logic [NR_W-1:0]            rf_rd,
    output logic [THREAD_CNT-1:0]      rf_tmask,
    output logic [THREAD_CNT*XLEN-1:0] rf_data,
    output logic                       rel_valid,
    output logic [WIS_W-1:0]           rel_wis,
    output logic [NR_W-1:0]            rel_rd,
    output logic [CNT_W-1:0]           pending_cnt,
    output logic                       proto_err
`ifdef VX_WB_SINK_PERF_EN
    ,
    output logic [31:0]                perf_wb_beats,
    output logic [31:0]                perf_rsv_stalls
`endif
);
    typedef enum logic {S_IDLE, S_BODY} state_t;

    state_t                           r_state     [NUM_WIS];
    state_t                           w_state_nxt [NUM_WIS];
    logic [NR_W-1:0]                  r_cur_rd    [NUM_WIS];
    logic [NR_W-1:0]                  w_cur_nxt   [NUM_WIS];
    logic [NUM_WIS-1:0][NUM_REGS-1:0] r_pending;
    logic [NUM_WIS-1:0][NUM_REGS-1:0] w_pending_nxt;

    logic                       r_rf_we;
    logic [WIS_W-1:0]           r_rf_wis;
    logic [NR_W-1:0]            r_rf_rd;
    logic [THREAD_CNT-1:0]      r_rf_tmask;
    logic [THREAD_CNT*XLEN-1:0] r_rf_data;
    logic                       r_rel_valid;
    logic [WIS_W-1:0]           r_rel_wis;
    logic [NR_W-1:0]            r_rel_rd;
    logic [CNT_W-1:0]           r_pending_cnt;
    logic                       r_proto_err;

    logic w_frame_err, w_eop_ok, w_rel, w_err, w_rsv_ready, w_accept, w_write;

    logic [UUID_W-1:0] w_unused_uuid;
    logic [XLEN-1:0]   w_unused_pc;
    assign w_unused_uuid = wb.wb_uuid;
    assign w_unused_pc   = wb.wb_PC;

    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur_rd;
        w_frame_err = 1'b0;
        w_eop_ok    = 1'b0;
        if (wb.wb_valid) begin
            if (r_state[wb.wb_wis] == S_BODY && !wb.wb_sop) begin
                if (wb.wb_rd != r_cur_rd[wb.wb_wis]) begin
                    w_frame_err = 1'b1;
                end else if (wb.wb_eop) begin
                    w_eop_ok                = 1'b1;
                    w_state_nxt[wb.wb_wis] = S_IDLE;
                end
            end else begin
                // A sop inside an open packet is flagged, then restarts it like a fresh sop
                if (r_state[wb.wb_wis] == S_BODY) w_frame_err = 1'b1;
                if (!wb.wb_sop) begin
                    w_frame_err = 1'b1;
                end else if (wb.wb_eop) begin
                    w_eop_ok                = 1'b1;
                    w_state_nxt[wb.wb_wis] = S_IDLE;
                end else begin
                    w_state_nxt[wb.wb_wis] = S_BODY;
                    w_cur_nxt[wb.wb_wis]   = wb.wb_rd;
                end
            end
        end

        w_rel       = w_eop_ok & r_pending[wb.wb_wis][wb.wb_rd];
        w_err       = w_frame_err | (w_eop_ok & ~r_pending[wb.wb_wis][wb.wb_rd]);
        w_rsv_ready = ~r_pending[rsv_wis][rsv_rd]
                    | (w_rel & (rsv_wis == wb.wb_wis) & (rsv_rd == wb.wb_rd));
        w_accept    = rsv_valid & w_rsv_ready;
        w_write     = wb.wb_valid & (|wb.wb_tmask);

        // Set after clear, so a same-cycle release and re-reservation leaves the bit held
        w_pending_nxt = r_pending;
        if (w_rel)    w_pending_nxt[wb.wb_wis][wb.wb_rd] = 1'b0;
        if (w_accept) w_pending_nxt[rsv_wis][rsv_rd]     = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_WIS; i++) begin
                r_state[i]  <= S_IDLE;
                r_cur_rd[i] <= '0;
            end
            r_pending     <= '0;
            r_rf_we       <= 1'b0;
            r_rf_wis      <= '0;
            r_rf_rd       <= '0;
            r_rf_tmask    <= '0;
            r_rf_data     <= '0;
            r_rel_valid   <= 1'b0;
            r_rel_wis     <= '0;
            r_rel_rd      <= '0;
            r_pending_cnt <= '0;
            r_proto_err   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cur_rd      <= w_cur_nxt;
            r_pending     <= w_pending_nxt;
            r_rf_we       <= w_write;
            if (w_write) begin
                r_rf_wis   <= wb.wb_wis;
                r_rf_rd    <= wb.wb_rd;
                r_rf_tmask <= wb.wb_tmask;
                r_rf_data  <= wb.wb_data;
            end
            r_rel_valid   <= w_rel;
            if (w_rel) begin
                r_rel_wis <= wb.wb_wis;
                r_rel_rd  <= wb.wb_rd;
            end
            r_pending_cnt <= r_pending_cnt + CNT_W'(w_accept) - CNT_W'(w_rel);
            r_proto_err   <= r_proto_err | w_err;
        end
    end

    assign rsv_ready   = w_rsv_ready;
    assign rf_we       = r_rf_we;
    assign rf_wis      = r_rf_wis;
    assign rf_rd       = r_rf_rd;
    assign rf_tmask    = r_rf_tmask;
    assign rf_data     = r_rf_data;
    assign rel_valid   = r_rel_valid;
    assign rel_wis     = r_rel_wis;
    assign rel_rd      = r_rel_rd;
    assign pending_cnt = r_pending_cnt;
    assign proto_err   = r_proto_err;

`ifdef VX_WB_SINK_PERF_EN
    logic [31:0] r_perf_beats;
    logic [31:0] r_perf_stalls;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_perf_beats  <= '0;
            r_perf_stalls <= '0;
        end else begin
            if (wb.wb_valid)              r_perf_beats  <= r_perf_beats + 32'd1;
            if (rsv_valid && !w_rsv_ready) r_perf_stalls <= r_perf_stalls + 32'd1;
        end
    end

    assign perf_wb_beats   = r_perf_beats;
    assign perf_rsv_stalls = r_perf_stalls;
`endif
endmodule

// File: tb/tb_vx_writeback_sink.sv
// Self-checking bench for vx_writeback_sink: directed scenarios plus randomized traffic
// against a packet-level reference model. Define VX_WB_SINK_PERF_EN to cover the perf counters.
module tb_vx_writeback_sink;
    localparam int TC = 4;
    localparam int XL = 32;
    localparam int NW = 4;
    localparam int NR = 64;
    localparam int WW = 2;
    localparam int RW = 6;
    localparam int CW = 9;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    vx_writeback_sink_if #(.THREAD_CNT(TC), .XLEN(XL), .WIS_W(WW), .NR_W(RW), .UUID_W(1)) wbif ();

    logic              rsv_valid;
    logic [WW-1:0]     rsv_wis;
    logic [RW-1:0]     rsv_rd;
    logic              rsv_ready;
    logic              rf_we;
    logic [WW-1:0]     rf_wis;
    logic [RW-1:0]     rf_rd;
    logic [TC-1:0]     rf_tmask;
    logic [TC*XL-1:0]  rf_data;
    logic              rel_valid;
    logic [WW-1:0]     rel_wis;
    logic [RW-1:0]     rel_rd;
    logic [CW-1:0]     pending_cnt;
    logic              proto_err;
`ifdef VX_WB_SINK_PERF_EN
    logic [31:0]       perf_wb_beats;
    logic [31:0]       perf_rsv_stalls;
`endif

    vx_writeback_sink #(
        .THREAD_CNT(TC), .XLEN(XL), .NUM_WIS(NW), .NUM_REGS(NR), .UUID_W(1)
    ) dut (
        .clk(clk), .reset(reset), .wb(wbif.slave),
        .rsv_valid(rsv_valid), .rsv_wis(rsv_wis), .rsv_rd(rsv_rd), .rsv_ready(rsv_ready),
        .rf_we(rf_we), .rf_wis(rf_wis), .rf_rd(rf_rd), .rf_tmask(rf_tmask), .rf_data(rf_data),
        .rel_valid(rel_valid), .rel_wis(rel_wis), .rel_rd(rel_rd),
        .pending_cnt(pending_cnt), .proto_err(proto_err)
`ifdef VX_WB_SINK_PERF_EN
        , .perf_wb_beats(perf_wb_beats), .perf_rsv_stalls(perf_rsv_stalls)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: which registers are reserved, which slots have a packet open.
    bit m_pend [NW][NR];
    bit m_open [NW];
    int m_cur  [NW];
    int m_cnt;
    bit m_err;
    int e_beats;
    int e_stalls;

    // Expectations for the cycle just clocked, plus the DUT rsv_ready sampled before the edge.
    bit             e_ready, s_ready;
    bit             e_rf_we, e_rel;
    logic [WW-1:0]  e_rf_wis, e_rel_wis;
    logic [RW-1:0]  e_rf_rd, e_rel_rd;
    logic [TC-1:0]  e_rf_tmask;
    logic [TC*XL-1:0] e_rf_data;

    task automatic idle();
        wbif.wb_valid = 1'b0;
        wbif.wb_uuid  = '0;
        wbif.wb_wis   = '0;
        wbif.wb_tmask = '0;
        wbif.wb_PC    = '0;
        wbif.wb_rd    = '0;
        wbif.wb_data  = '0;
        wbif.wb_sop   = 1'b0;
        wbif.wb_eop   = 1'b0;
        rsv_valid     = 1'b0;
        rsv_wis       = '0;
        rsv_rd        = '0;
    endtask

    task automatic set_beat(input int w, input int r, input logic [TC-1:0] tm,
                            input logic [TC*XL-1:0] d, input bit sop, input bit eop);
        wbif.wb_valid = 1'b1;
        wbif.wb_uuid  = 1'($urandom);
        wbif.wb_wis   = WW'(w);
        wbif.wb_tmask = tm;
        wbif.wb_PC    = $urandom;
        wbif.wb_rd    = RW'(r);
        wbif.wb_data  = d;
        wbif.wb_sop   = sop;
        wbif.wb_eop   = eop;
    endtask

    task automatic set_rsv(input bit v, input int w, input int r);
        rsv_valid = v;
        rsv_wis   = WW'(w);
        rsv_rd    = RW'(r);
    endtask

    function automatic logic [TC*XL-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        set_beat(1, 1, 4'hF, rand_data(), 1'b0, 1'b1);
        set_rsv(1'b1, 2, 2);
        @(posedge clk); #1;
        reset = 1'b1;
        idle();
        for (int w = 0; w < NW; w++) begin
            m_open[w] = 1'b0;
            m_cur[w]  = 0;
            for (int r = 0; r < NR; r++) m_pend[w][r] = 1'b0;
        end
        m_cnt    = 0;
        m_err    = 1'b0;
        e_beats  = 0;
        e_stalls = 0;
    endtask

    // Apply the packet rules to the driven beat/reservation, then clock one cycle.
    task automatic advance();
        int  w, r, rw, rr;
        bit  closes, bad, rel, acc;
        #1;
        w  = int'(wbif.wb_wis);
        r  = int'(wbif.wb_rd);
        rw = int'(rsv_wis);
        rr = int'(rsv_rd);
        closes = 1'b0;
        bad    = 1'b0;
        rel    = 1'b0;
        if (wbif.wb_valid) begin
            if (wbif.wb_sop) begin
                if (m_open[w]) bad = 1'b1;
                m_open[w] = 1'b1;
                m_cur[w]  = r;
                closes    = wbif.wb_eop;
            end else if (!m_open[w] || r != m_cur[w]) begin
                bad = 1'b1;
            end else begin
                closes = wbif.wb_eop;
            end
            if (closes) begin
                m_open[w] = 1'b0;
                if (m_pend[w][r]) rel = 1'b1;
                else              bad = 1'b1;
            end
        end
        e_ready = !m_pend[rw][rr] || (rel && rw == w && rr == r);
        s_ready = rsv_ready;
        acc     = rsv_valid && e_ready;
        if (rel) m_pend[w][r] = 1'b0;
        if (acc) m_pend[rw][rr] = 1'b1;
        m_cnt = m_cnt + int'(acc) - int'(rel);
        if (bad) m_err = 1'b1;
        if (wbif.wb_valid) e_beats++;
        if (rsv_valid && !e_ready) e_stalls++;
        e_rf_we    = wbif.wb_valid && (wbif.wb_tmask != '0);
        e_rf_wis   = wbif.wb_wis;
        e_rf_rd    = wbif.wb_rd;
        e_rf_tmask = wbif.wb_tmask;
        e_rf_data  = wbif.wb_data;
        e_rel      = rel;
        e_rel_wis  = wbif.wb_wis;
        e_rel_rd   = wbif.wb_rd;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        idle();
        do_reset();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got %0b want 0", rf_we); end
        checks++; if (rel_valid !== 1'b0) begin errors++; $display("FAIL reset_rel_valid got %0b want 0", rel_valid); end
        checks++; if (pending_cnt !== '0) begin errors++; $display("FAIL reset_pending_cnt got %0d want 0", pending_cnt); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err got %0b want 0", proto_err); end
        checks++;
        if ({rf_wis, rf_rd, rf_tmask, rel_wis, rel_rd} !== '0 || rf_data !== '0) begin
            errors++; $display("FAIL reset_fields got wis=%0d rd=%0d tm=%h data=%h", rf_wis, rf_rd, rf_tmask, rf_data);
        end
        set_rsv(1'b0, 3, 63);
        #1;
        checks++; if (rsv_ready !== 1'b1) begin errors++; $display("FAIL reset_rsv_ready got %0b want 1", rsv_ready); end
    endtask

    task automatic test_single_beat();
        logic [TC*XL-1:0] d;
        d = {32'd4, 32'd3, 32'd2, 32'd1};
        idle(); set_rsv(1'b1, 1, 5); advance();
        checks++; if (pending_cnt !== CW'(1)) begin errors++; $display("FAIL single_cnt_rsv got %0d want 1", pending_cnt); end
        idle(); set_beat(1, 5, 4'b1011, d, 1'b1, 1'b1); advance();
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL single_rf_we got %0b want 1", rf_we); end
        checks++; if (rf_tmask !== 4'b1011) begin errors++; $display("FAIL single_tmask got %b want 1011", rf_tmask); end
        checks++; if (rf_data !== d || rf_wis !== 2'd1 || rf_rd !== 6'd5) begin
            errors++; $display("FAIL single_rf_fields got wis=%0d rd=%0d data=%h", rf_wis, rf_rd, rf_data); end
        checks++; if (rel_valid !== 1'b1 || rel_wis !== 2'd1 || rel_rd !== 6'd5) begin
            errors++; $display("FAIL single_rel got v=%0b wis=%0d rd=%0d want 1/1/5", rel_valid, rel_wis, rel_rd); end
        checks++; if (pending_cnt !== '0) begin errors++; $display("FAIL single_cnt_rel got %0d want 0", pending_cnt); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL single_proto_err got %0b want 0", proto_err); end
        idle(); advance();
        checks++; if (rf_we !== 1'b0 || rel_valid !== 1'b0) begin
            errors++; $display("FAIL single_idle got we=%0b rel=%0b want 0/0", rf_we, rel_valid); end
    endtask

    task automatic test_multi_beat();
        idle(); set_rsv(1'b1, 2, 7); advance();
        for (int i = 0; i < 3; i++) begin
            idle();
            set_beat(2, 7, 4'hF, rand_data(), i == 0, i == 2);
            set_rsv(1'b0, 2, 7);
            advance();
            checks++; if (s_ready !== (i == 2)) begin
                errors++; $display("FAIL multi_rsv_ready beat %0d got %0b want %0b", i, s_ready, i == 2); end
            checks++; if (rf_we !== 1'b1 || rf_data !== e_rf_data) begin
                errors++; $display("FAIL multi_rf beat %0d got we=%0b data=%h want 1 %h", i, rf_we, rf_data, e_rf_data); end
            checks++; if (rel_valid !== (i == 2)) begin
                errors++; $display("FAIL multi_rel beat %0d got %0b want %0b", i, rel_valid, i == 2); end
        end
        checks++; if (pending_cnt !== '0) begin errors++; $display("FAIL multi_cnt got %0d want 0", pending_cnt); end
    endtask

    task automatic test_sop_restart();
        idle(); set_rsv(1'b1, 0, 3); advance();
        idle(); set_beat(0, 3, 4'h1, rand_data(), 1'b1, 1'b0); advance();
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL restart_first got %0b want 0", proto_err); end
        idle(); set_beat(0, 3, 4'h3, rand_data(), 1'b1, 1'b0); advance();
        checks++; if (proto_err !== 1'b1 || rf_we !== 1'b1) begin
            errors++; $display("FAIL restart_err got err=%0b we=%0b want 1/1", proto_err, rf_we); end
        idle(); set_beat(0, 3, 4'h7, rand_data(), 1'b0, 1'b1); advance();
        checks++; if (rel_valid !== 1'b1 || rel_wis !== 2'd0 || rel_rd !== 6'd3) begin
            errors++; $display("FAIL restart_rel got v=%0b wis=%0d rd=%0d want 1/0/3", rel_valid, rel_wis, rel_rd); end
        checks++; if (pending_cnt !== '0) begin errors++; $display("FAIL restart_cnt got %0d want 0", pending_cnt); end
    endtask

    task automatic test_rsv_rel_same();
        idle(); do_reset();
        set_rsv(1'b1, 3, 9); advance();
        idle(); set_beat(3, 9, 4'hF, rand_data(), 1'b1, 1'b1); set_rsv(1'b1, 3, 9); advance();
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL same_rsv_ready got %0b want 1", s_ready); end
        checks++; if (rel_valid !== 1'b1) begin errors++; $display("FAIL same_rel got %0b want 1", rel_valid); end
        checks++; if (pending_cnt !== CW'(1)) begin errors++; $display("FAIL same_cnt got %0d want 1", pending_cnt); end
        idle(); set_rsv(1'b0, 3, 9); advance();
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL same_bit_held got %0b want 0", s_ready); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL same_proto_err got %0b want 0", proto_err); end
    endtask

    task automatic test_reset_mid_packet();
        idle(); set_rsv(1'b1, 1, 2); advance();
        idle(); set_beat(1, 2, 4'hF, rand_data(), 1'b1, 1'b0); advance();
        do_reset();
        checks++; if (rf_we !== 1'b0 || rel_valid !== 1'b0 || pending_cnt !== '0 || proto_err !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs got we=%0b rel=%0b cnt=%0d err=%0b want all 0",
                               rf_we, rel_valid, pending_cnt, proto_err); end
        set_beat(1, 2, 4'h2, rand_data(), 1'b0, 1'b1); advance();
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL midrst_proto_err got %0b want 1", proto_err); end
        checks++; if (rf_we !== 1'b1 || rel_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_beat got we=%0b rel=%0b want 1/0", rf_we, rel_valid); end
    endtask

    task automatic test_random();
        int w, r;
        bit sop, eop;
        for (int seg = 0; seg < 4; seg++) begin
            idle(); do_reset();
            for (int n = 0; n < 150; n++) begin
                idle();
                if ($urandom_range(3) != 0) begin
                    w = int'($urandom_range(NW - 1));
                    if (m_open[w] && $urandom_range(9) != 0) begin
                        r   = m_cur[w];
                        sop = ($urandom_range(15) == 0);
                    end else begin
                        r   = int'($urandom_range(3));
                        sop = ($urandom_range(15) != 0);
                    end
                    eop = $urandom_range(1) == 1;
                    set_beat(w, r, ($urandom_range(5) == 0) ? 4'h0 : 4'($urandom), rand_data(), sop, eop);
                end
                set_rsv($urandom_range(1) == 1, int'($urandom_range(NW - 1)), int'($urandom_range(3)));
                advance();
                checks++; if (s_ready !== e_ready) begin
                    errors++; $display("FAIL rnd_rsv_ready cyc %0d got %0b want %0b", n, s_ready, e_ready); end
                checks++; if (rf_we !== e_rf_we) begin
                    errors++; $display("FAIL rnd_rf_we cyc %0d got %0b want %0b", n, rf_we, e_rf_we); end
                if (e_rf_we) begin
                    checks++;
                    if (rf_wis !== e_rf_wis || rf_rd !== e_rf_rd || rf_tmask !== e_rf_tmask || rf_data !== e_rf_data) begin
                        errors++; $display("FAIL rnd_rf_fields cyc %0d got %0d/%0d/%h want %0d/%0d/%h", n,
                                           rf_wis, rf_rd, rf_tmask, e_rf_wis, e_rf_rd, e_rf_tmask);
                    end
                end
                checks++; if (rel_valid !== e_rel) begin
                    errors++; $display("FAIL rnd_rel_valid cyc %0d got %0b want %0b", n, rel_valid, e_rel); end
                if (e_rel) begin
                    checks++; if (rel_wis !== e_rel_wis || rel_rd !== e_rel_rd) begin
                        errors++; $display("FAIL rnd_rel_fields cyc %0d got %0d/%0d want %0d/%0d", n,
                                           rel_wis, rel_rd, e_rel_wis, e_rel_rd); end
                end
                checks++; if (pending_cnt !== CW'(m_cnt)) begin
                    errors++; $display("FAIL rnd_pending_cnt cyc %0d got %0d want %0d", n, pending_cnt, m_cnt); end
                checks++; if (proto_err !== m_err) begin
                    errors++; $display("FAIL rnd_proto_err cyc %0d got %0b want %0b", n, proto_err, m_err); end
            end
        end
    endtask

`ifdef VX_WB_SINK_PERF_EN
    task automatic test_perf();
        idle(); do_reset();
        checks++; if (perf_wb_beats !== 32'd0 || perf_rsv_stalls !== 32'd0) begin
            errors++; $display("FAIL perf_reset got %0d/%0d want 0/0", perf_wb_beats, perf_rsv_stalls); end
        for (int i = 0; i < 10; i++) begin
            idle(); set_beat(i % NW, 10 + i, 4'($urandom), rand_data(), 1'b1, 1'b0); advance();
        end
        idle(); set_rsv(1'b1, 0, 1); advance();
        for (int i = 0; i < 3; i++) begin
            idle(); set_rsv(1'b1, 0, 1); advance();
        end
        idle(); advance();
        checks++; if (perf_wb_beats !== 32'd10) begin
            errors++; $display("FAIL perf_wb_beats got %0d want 10", perf_wb_beats); end
        checks++; if (perf_rsv_stalls !== 32'd3) begin
            errors++; $display("FAIL perf_rsv_stalls got %0d want 3", perf_rsv_stalls); end
        checks++; if (perf_wb_beats !== 32'(e_beats) || perf_rsv_stalls !== 32'(e_stalls)) begin
            errors++; $display("FAIL perf_model got %0d/%0d want %0d/%0d", perf_wb_beats, perf_rsv_stalls, e_beats, e_stalls); end
    endtask
`endif

    initial begin
        idle();
        test_reset();
        test_single_beat();
        test_multi_beat();
        test_sop_restart();
        test_rsv_rel_same();
        test_reset_mid_packet();
        test_random();
`ifdef VX_WB_SINK_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vx_writeback_sink.md
Name: vx_writeback_sink

Overview:
- Receiving end of the writeback valid/data channel. The channel carries uuid, wis, tmask, PC, rd, per-thread data, sop and eop, and has no backpressure.
- Registers each beat into a register-file write port.
- Tracks sop/eop packet framing per issue slot (wis), and releases the scoreboard pending bit for rd on eop.
- Sits between the commit stage and the operand/register-file block of each issue slice.

Parameters:
- THREAD_CNT, 4, lanes per writeback beat
- XLEN, 32, data width per lane
- NUM_WIS, 4, issue slots tracked; WIS_W = max(1, clog2(NUM_WIS))
- NUM_REGS, 64, architectural registers per slot; NR_W = clog2(NUM_REGS)
- UUID_W, 1, uuid width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-low reset
- wb_valid  in  1  writeback beat valid
- wb_uuid  in  UUID_W  instruction uuid
- wb_wis  in  WIS_W  issue slot
- wb_tmask  in  THREAD_CNT  lane mask
- wb_PC  in  XLEN  instruction PC
- wb_rd  in  NR_W  destination register
- wb_data  in  THREAD_CNT*XLEN  lane data, lane 0 in LSBs
- wb_sop  in  1  first beat of packet
- wb_eop  in  1  last beat of packet
- rsv_valid  in  1  issue requests reservation of rsv_rd
- rsv_wis  in  WIS_W  reserving slot
- rsv_rd  in  NR_W  register to reserve
- rsv_ready  out  1  reservation accepted
- rf_we  out  1  register-file write enable
- rf_wis  out  WIS_W  write slot
- rf_rd  out  NR_W  write register
- rf_tmask  out  THREAD_CNT  write lane mask
- rf_data  out  THREAD_CNT*XLEN  write data
- rel_valid  out  1  pending bit released this cycle
- rel_wis  out  WIS_W  released slot
- rel_rd  out  NR_W  released register
- pending_cnt  out  clog2(NUM_WIS*NUM_REGS+1)  total outstanding reservations
- proto_err  out  1  sticky framing error

Behaviour:
- Reset (reset==0 at a clk edge):
  - pending table, all framing FSMs, rf_we, rel_valid, pending_cnt, proto_err all go to 0; rf_* and rel_* fields go to 0.
  - Reset mid-packet discards the packet's state.
  - wb_valid during reset is ignored.
- rsv_ready is combinational: rsv_ready = !pending[rsv_wis][rsv_rd] | (release of the same wis/rd this cycle).
  - A reservation is accepted when rsv_valid & rsv_ready; the pending bit is set at the next edge.
  - If rsv_valid is low, rsv_ready still reflects the table state.
- Register-file write path: 1-cycle latency, no bubbles.
  - A beat with wb_valid & |wb_tmask drives rf_we=1 next cycle, with the beat's wis/rd/tmask/data.
  - A beat with tmask==0 produces no write but is still framed.
- Framing FSM, one per wis; states IDLE and BODY; cur_rd latched per slot.
  - IDLE + sop & eop: single-beat packet; release; stay IDLE.
  - IDLE + sop & !eop: latch cur_rd; go to BODY.
  - IDLE + !sop: error; beat is still written; no release.
  - BODY + !sop & eop & rd==cur_rd: release; go to IDLE.
  - BODY + !sop & !eop & rd==cur_rd: stay in BODY.
  - BODY + sop: error; restart the packet per the IDLE rules.
  - BODY + rd!=cur_rd: error; stay in BODY.
- Release:
  - On a legal eop, clear pending[wis][rd] at the edge. rel_valid pulses 1 cycle, aligned with rf_we of that eop beat.
  - eop for a non-pending register sets proto_err; no clear; no rel_valid.
- Simultaneous reserve and release of the same wis/rd:
  - The release is honoured and the reservation accepted.
  - The bit remains 1; rel_valid still pulses; pending_cnt is unchanged.
- pending_cnt: +1 per accepted reservation, -1 per release, net 0 when both happen in the same cycle. It never wraps, because the table bounds it.
- proto_err is sticky until reset.

Optional Feature:
- Macro VX_WB_SINK_PERF_EN.
- When defined, adds outputs:
  - perf_wb_beats (32 bits): counts valid beats.
  - perf_rsv_stalls (32 bits): counts cycles with rsv_valid & !rsv_ready.
  - Both wrap modulo 2^32 and reset to 0.
- When undefined, these ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reserve wis=1 rd=5, then a single beat sop=eop=1 wis=1 rd=5 tmask=4'b1011 data=lanes {1,2,3,4} -> next cycle rf_we=1, rf_tmask=1011; rel_valid=1 rel_wis=1 rel_rd=5; pending_cnt 1->0; proto_err=0.
- Reserve wis=2 rd=7, then a 3-beat packet (sop; mid; eop) all rd=7 -> three consecutive rf_we pulses; rel_valid only with the third; rsv_ready for wis=2 rd=7 is 0 until the eop cycle.
- With wis=0 in BODY, a new sop arrives -> proto_err=1 at the next edge; the packet restarts; the following legal eop releases normally.
- Reserve wis=3 rd=9, then in one cycle drive eop for wis=3 rd=9 and rsv_valid for wis=3 rd=9 -> rsv_ready=1; pending bit stays 1; pending_cnt unchanged; rel_valid=1.
- Mid-packet, assert reset=0 for 1 cycle -> all outputs 0 and pending_cnt=0; a following non-sop beat sets proto_err.
- With VX_WB_SINK_PERF_EN defined: 10 valid beats and 3 blocked reservation cycles -> perf_wb_beats=10, perf_rsv_stalls=3.
